// File: rtl/mem_if.sv
// Request/response bundle between the multicycle control section (master)
// and the unified instruction/data memory (slave).
interface mem_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;

  modport master (
    output mem_read, mem_write, addr, wdata,
    input  rdata, ready, err, busy
  );

  modport slave (
    input  mem_read, mem_write, addr, wdata,
    output rdata, ready, err, busy
  );
endinterface

// File: rtl/mem_responder.sv
// Unified instruction/data memory slave with a fixed number of wait states.
// Every request completes with a one-cycle ready pulse; malformed requests
// (both strobes, or a non-word-aligned address) are timed normally but
// reported through err instead of touching memory or rdata.
module mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2,
  parameter     INIT_FILE   = ""
) (
  input  logic  clk,
  input  logic  reset,
  mem_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int DEPTH = 2 ** ADDR_W;

  state_t              state, state_next;
  logic [3:0]          cnt;
  logic                ready_q, err_q, busy_q;
  logic [31:0]         rdata_q;

  // Request captured at acceptance; governs the access from then on.
  logic [ADDR_W-1:0]   idx_lat;
  logic                write_lat, err_lat;
  logic [31:0]         wdata_lat;

  logic [31:0]         mem [DEPTH];

  // Live request decode, only meaningful while in IDLE.
  logic                req, req_err;
  // Effective access fields: with zero wait states the memory action
  // happens on the acceptance edge itself, before the latches hold anything.
  logic [ADDR_W-1:0]   acc_idx;
  logic                acc_write, acc_err;
  logic [31:0]         acc_wdata;
  logic                enter_resp;

  // Address bits above the word index are deliberately ignored (wrap).
  logic                unused_addr;
  assign unused_addr = ^{bus.addr[31:ADDR_W+2]};

  assign req     = bus.mem_read | bus.mem_write;
  assign req_err = (bus.mem_read & bus.mem_write) | (bus.addr[1:0] != 2'b00);

  assign acc_idx   = (state == IDLE) ? bus.addr[ADDR_W+1:2] : idx_lat;
  assign acc_write = (state == IDLE) ? bus.mem_write        : write_lat;
  assign acc_err   = (state == IDLE) ? req_err              : err_lat;
  assign acc_wdata = (state == IDLE) ? bus.wdata            : wdata_lat;

  assign enter_resp = !reset && (state != RESP) && (state_next == RESP);

  // Next-state decode.
  always_comb begin
    // NOTE: assigning the default first guarantees every path drives
    // state_next, so no latch is inferred for the unlisted cases.
    state_next = state;
    unique case (state)
      IDLE: if (req) state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT: if (cnt == 4'd1) state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register, wait counter and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state   <= state_next;
      ready_q <= (state_next == RESP);
      err_q   <= (state_next == RESP) && acc_err;
      busy_q  <= (state_next != IDLE);
      if (state == IDLE && req)
        cnt <= 4'(WAIT_CYCLES);
      else if (state == WAIT)
        cnt <= cnt - 4'd1;
      if (enter_resp && !acc_err && !acc_write)
        rdata_q <= mem[acc_idx];
    end
  end

  // Capture the request on acceptance; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      idx_lat   <= bus.addr[ADDR_W+1:2];
      write_lat <= bus.mem_write;
      err_lat   <= req_err;
      wdata_lat <= bus.wdata;
    end
  end

  // Memory write on the edge entering RESP for valid writes only.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; contents must survive reset and a
    // resettable array could not map onto block RAM.
    if (enter_resp && acc_write && !acc_err)
      mem[acc_idx] <= acc_wdata;
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
  assign bus.err   = err_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: one responder with two wait states and one with none,
// sharing a clock/reset; a select bit steers strobes to one of them.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;           // 0: two-wait-state unit, 1: zero-wait unit
  logic        rd = 1'b0, wr = 1'b0;
  logic [31:0] a = '0, d = '0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_if bus2();
  mem_if bus0();

  assign bus2.mem_read  = rd & ~sel;
  assign bus2.mem_write = wr & ~sel;
  assign bus2.addr      = a;
  assign bus2.wdata     = d;
  assign bus0.mem_read  = rd & sel;
  assign bus0.mem_write = wr & sel;
  assign bus0.addr      = a;
  assign bus0.wdata     = d;

  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(2), .INIT_FILE("")) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave)
  );

  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0), .INIT_FILE("")) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave)
  );

  logic        ready_m, err_m, busy_m;
  logic [31:0] rdata_m;
  assign ready_m = sel ? bus0.ready : bus2.ready;
  assign err_m   = sel ? bus0.err   : bus2.err;
  assign busy_m  = sel ? bus0.busy  : bus2.busy;
  assign rdata_m = sel ? bus0.rdata : bus2.rdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and hold it until ready; reports the number of
  // edges from driving to seeing ready (99 on timeout), the response,
  // and ready one cycle later.
  task automatic access(input logic s, input logic r, input logic w,
                        input logic [31:0] ad, input logic [31:0] dt,
                        output int lat, output logic [31:0] rdo,
                        output logic erro, output logic rdy_after);
    sel = s; rd = r; wr = w; a = ad; d = dt;
    lat = 99; rdo = 'x; erro = 'x;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (ready_m === 1'b1) begin
        lat = n; rdo = rdata_m; erro = err_m;
        break;
      end
    end
    rd = 1'b0; wr = 1'b0;
    tick();
    rdy_after = ready_m;
  endtask

  task automatic test_reset();
    reset = 1'b1; rd = 1'b0; wr = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if ({bus2.ready, bus2.err, bus2.busy} !== 3'b000 || bus2.rdata !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_idle2 cyc%0d: got r/e/b=%b%b%b rdata=%h expected 000 rdata=0",
                 i, bus2.ready, bus2.err, bus2.busy, bus2.rdata);
      end
      vectors++;
      if ({bus0.ready, bus0.err, bus0.busy} !== 3'b000 || bus0.rdata !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_idle0 cyc%0d: got r/e/b=%b%b%b rdata=%h expected 000 rdata=0",
                 i, bus0.ready, bus0.err, bus0.busy, bus0.rdata);
      end
    end
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rdo; logic erro, ra;
    // Busy must rise right after acceptance.
    sel = 0; wr = 1; a = 32'h10; d = 32'hDEADBEEF;
    tick();
    vectors++;
    if (bus2.busy !== 1'b1 || bus2.ready !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_after_accept: got busy=%b ready=%b expected 1 0", bus2.busy, bus2.ready);
    end
    wr = 0;
    reset = 1'b1; tick(); reset = 1'b0;     // clean restart for the timed access
    access(0, 0, 1, 32'h10, 32'hDEADBEEF, lat, rdo, erro, ra);
    vectors++;
    if (lat !== 3 || erro !== 1'b0 || ra !== 1'b0) begin
      miscompares++;
      $display("FAIL write_10: got lat=%0d err=%b ready_after=%b expected 3 0 0", lat, erro, ra);
    end
    access(0, 1, 0, 32'h10, 32'h0, lat, rdo, erro, ra);
    vectors++;
    if (lat !== 3 || rdo !== 32'hDEADBEEF || erro !== 1'b0 || ra !== 1'b0) begin
      miscompares++;
      $display("FAIL read_10: got lat=%0d rdata=%h err=%b ready_after=%b expected 3 deadbeef 0 0",
               lat, rdo, erro, ra);
    end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rdo; logic erro, ra;
    access(0, 0, 1, 32'h20, 32'h20202020, lat, rdo, erro, ra);
    // Both strobes: error, no write, rdata keeps the last read value.
    access(0, 1, 1, 32'h20, 32'hFFFFFFFF, lat, rdo, erro, ra);
    vectors++;
    if (lat !== 3 || erro !== 1'b1 || rdo !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL both_strobes: got lat=%0d err=%b rdata=%h expected 3 1 deadbeef", lat, erro, rdo);
    end
    // Misaligned write into the same word: error, no write.
    access(0, 0, 1, 32'h22, 32'h1, lat, rdo, erro, ra);
    vectors++;
    if (lat !== 3 || erro !== 1'b1 || rdo !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL misaligned_write: got lat=%0d err=%b rdata=%h expected 3 1 deadbeef", lat, erro, rdo);
    end
    access(0, 1, 0, 32'h20, 32'h0, lat, rdo, erro, ra);
    vectors++;
    if (rdo !== 32'h20202020 || erro !== 1'b0) begin
      miscompares++;
      $display("FAIL read_20_after_err: got rdata=%h err=%b expected 20202020 0", rdo, erro);
    end
  endtask

  task automatic test_wrap();
    int lat; logic [31:0] rdo; logic erro, ra;
    access(0, 0, 1, 32'h400, 32'h5A5A5A5A, lat, rdo, erro, ra);
    access(0, 1, 0, 32'h0, 32'h0, lat, rdo, erro, ra);
    vectors++;
    if (rdo !== 32'h5A5A5A5A || erro !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_read_0: got rdata=%h err=%b expected 5a5a5a5a 0", rdo, erro);
    end
    access(0, 1, 0, 32'h8000_0010, 32'h0, lat, rdo, erro, ra);
    vectors++;
    if (rdo !== 32'hDEADBEEF || erro !== 1'b0) begin
      miscompares++;
      $display("FAIL high_bits_ignored: got rdata=%h err=%b expected deadbeef 0", rdo, erro);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_rdy;
    sel = 0; rd = 1; wr = 0; a = 32'h10;
    for (int n = 1; n <= 12; n++) begin
      tick();
      exp_rdy = (n % 4 == 3);
      vectors++;
      if (bus2.ready !== exp_rdy || (exp_rdy && bus2.rdata !== 32'hDEADBEEF)) begin
        miscompares++;
        $display("FAIL back_to_back n=%0d: got ready=%b rdata=%h expected ready=%b rdata=deadbeef",
                 n, bus2.ready, bus2.rdata, exp_rdy);
      end
    end
    rd = 0;
    repeat (2) tick();
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rdo; logic erro, ra;
    access(0, 0, 1, 32'h8, 32'hCAFEF00D, lat, rdo, erro, ra);
    sel = 0; wr = 1; a = 32'h8; d = 32'h12345678;
    tick();                  // accepted, WAIT
    tick();                  // WAIT, one left
    reset = 1'b1; wr = 0;
    tick();
    vectors++;
    if (bus2.ready !== 1'b0 || bus2.busy !== 1'b0 || bus2.rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid_abort: got ready=%b busy=%b rdata=%h expected 0 0 0",
               bus2.ready, bus2.busy, bus2.rdata);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (bus2.ready !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_mid_no_ready cyc%0d: got %b expected 0", i, bus2.ready);
      end
    end
    access(0, 1, 0, 32'h8, 32'h0, lat, rdo, erro, ra);
    vectors++;
    if (rdo !== 32'hCAFEF00D || lat !== 3) begin
      miscompares++;
      $display("FAIL reset_mid_old_value: got rdata=%h lat=%0d expected cafef00d 3", rdo, lat);
    end
  endtask

  task automatic test_zero_wait();
    int lat; logic [31:0] rdo; logic erro, ra;
    access(1, 0, 1, 32'h4, 32'h11111111, lat, rdo, erro, ra);
    vectors++;
    if (lat !== 1 || erro !== 1'b0 || ra !== 1'b0) begin
      miscompares++;
      $display("FAIL zw_write_4: got lat=%0d err=%b ready_after=%b expected 1 0 0", lat, erro, ra);
    end
    access(1, 0, 1, 32'h8, 32'h22222222, lat, rdo, erro, ra);
    // Read 0x4, then retarget to 0x8 while in RESP, strobe held.
    sel = 1; rd = 1; wr = 0; a = 32'h4;
    tick();
    vectors++;
    if (bus0.ready !== 1'b1 || bus0.busy !== 1'b1 || bus0.rdata !== 32'h11111111) begin
      miscompares++;
      $display("FAIL zw_read_4: got ready=%b busy=%b rdata=%h expected 1 1 11111111",
               bus0.ready, bus0.busy, bus0.rdata);
    end
    a = 32'h8;
    tick();
    vectors++;
    if (bus0.ready !== 1'b0 || bus0.rdata !== 32'h11111111) begin
      miscompares++;
      $display("FAIL zw_idle_gap: got ready=%b rdata=%h expected 0 11111111", bus0.ready, bus0.rdata);
    end
    tick();
    vectors++;
    if (bus0.ready !== 1'b1 || bus0.rdata !== 32'h22222222) begin
      miscompares++;
      $display("FAIL zw_new_addr: got ready=%b rdata=%h expected 1 22222222", bus0.ready, bus0.rdata);
    end
    rd = 0;
    tick();
    sel = 0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_errors();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_zero_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
